// File: rtl/lif_seq_pkg.sv
// Shared types and constants for the LIF configuration sequencer.
// LIF_SEQ_RUN_LIMIT_EN adds the LD_LEN load state for the bounded-run option.
package lif_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_THR = 3'd1,
    LD_DEC = 3'd2,
    LD_REF = 3'd3,
    LD_PRE = 3'd4,
    APPLY  = 3'd5,
    RUN    = 3'd6
`ifdef LIF_SEQ_RUN_LIMIT_EN
    ,
    LD_LEN = 3'd7
`endif
  } lif_state_e;

  localparam logic [7:0] CMD_LOAD  = 8'h01;
  localparam logic [7:0] CMD_START = 8'h02;
  localparam logic [7:0] CMD_STOP  = 8'h03;

  localparam logic [7:0] THR_RST = 8'd128;
  localparam logic [7:0] DEC_RST = 8'd1;
  localparam logic [7:0] REF_RST = 8'd2;

endpackage

// File: rtl/lif_config_sequencer_timestep.sv
// Prescaled timestep generator: one neuron_en pulse every prescale+1 enabled cycles.
module lif_timestep_gen #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [DATA_W-1:0] prescale,
  output logic              neuron_en
);

  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              en_q, en_d;

  always_comb begin
    cnt_d = cnt_q;
    en_d  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == prescale) begin
        cnt_d = '0;
        en_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + DATA_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en_d;
    end
  end

  assign neuron_en = en_q;

endmodule

// File: rtl/lif_config_sequencer.sv
// Command/config sequencer for the LIF neuron core: config registers, run FSM, spike counter.
// Define LIF_SEQ_RUN_LIMIT_EN to add a run_len byte that ends a run after that many timesteps.
module lif_config_sequencer
  import lif_seq_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_SPIKES = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [NUM_SPIKES-1:0] spike_in,
  output logic [DATA_W-1:0]     threshold,
  output logic [DATA_W-1:0]     decay,
  output logic [DATA_W-1:0]     refractory_period,
  output logic                  neuron_en,
  output logic                  cfg_update,
  output logic                  running,
  output logic [CNT_W-1:0]      spike_count,
  output logic                  cmd_err
);

  lif_state_e        state_q, state_d;
  logic [DATA_W-1:0] thr_sh_q, thr_sh_d, dec_sh_q, dec_sh_d, ref_sh_q, ref_sh_d, pre_sh_q, pre_sh_d;
  logic [DATA_W-1:0] thr_q, thr_d, dec_q, dec_d, ref_q, ref_d, pre_q, pre_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, pop_s;
  logic [CNT_W:0]    sum_s;
  logic              err_q, err_d, ready_q, upd_q, run_q;
  logic              xfer_s, ts_clear_s, neuron_en_s;
`ifdef LIF_SEQ_RUN_LIMIT_EN
  logic [DATA_W-1:0] len_sh_q, len_sh_d, len_q, len_d, pulse_q, pulse_d;
`endif

  always_comb begin
    pop_s = '0;
    for (int i = 0; i < NUM_SPIKES; i++) begin
      pop_s = pop_s + CNT_W'(spike_in[i]);
    end
    sum_s = {1'b0, cnt_q} + {1'b0, pop_s};
  end

  always_comb begin
    state_d    = state_q;
    thr_sh_d   = thr_sh_q;
    dec_sh_d   = dec_sh_q;
    ref_sh_d   = ref_sh_q;
    pre_sh_d   = pre_sh_q;
    thr_d      = thr_q;
    dec_d      = dec_q;
    ref_d      = ref_q;
    pre_d      = pre_q;
    err_d      = err_q;
    ts_clear_s = 1'b0;
`ifdef LIF_SEQ_RUN_LIMIT_EN
    len_sh_d   = len_sh_q;
    len_d      = len_q;
    pulse_d    = pulse_q;
`endif
    xfer_s = cfg_valid && ready_q;
    // Saturating spike accumulation only while running.
    if (state_q == RUN) begin
      cnt_d = sum_s[CNT_W] ? {CNT_W{1'b1}} : sum_s[CNT_W-1:0];
    end else begin
      cnt_d = cnt_q;
    end
    case (state_q)
      IDLE: begin
        if (xfer_s) begin
          if (cfg_data == DATA_W'(CMD_LOAD)) begin
            state_d = LD_THR;
          end else if (cfg_data == DATA_W'(CMD_START)) begin
            state_d    = RUN;
            cnt_d      = '0;
            ts_clear_s = 1'b1;
`ifdef LIF_SEQ_RUN_LIMIT_EN
            pulse_d    = '0;
`endif
          end else if (cfg_data != DATA_W'(CMD_STOP)) begin
            err_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LD_THR: if (xfer_s) begin thr_sh_d = cfg_data; state_d = LD_DEC; end else state_d = LD_THR;
      LD_DEC: if (xfer_s) begin dec_sh_d = cfg_data; state_d = LD_REF; end else state_d = LD_DEC;
      LD_REF: if (xfer_s) begin ref_sh_d = cfg_data; state_d = LD_PRE; end else state_d = LD_REF;
`ifdef LIF_SEQ_RUN_LIMIT_EN
      LD_PRE: if (xfer_s) begin pre_sh_d = cfg_data; state_d = LD_LEN; end else state_d = LD_PRE;
      LD_LEN: if (xfer_s) begin len_sh_d = cfg_data; state_d = APPLY; end else state_d = LD_LEN;
`else
      LD_PRE: if (xfer_s) begin pre_sh_d = cfg_data; state_d = APPLY; end else state_d = LD_PRE;
`endif
      APPLY: begin
        thr_d   = thr_sh_q;
        dec_d   = dec_sh_q;
        ref_d   = ref_sh_q;
        pre_d   = pre_sh_q;
`ifdef LIF_SEQ_RUN_LIMIT_EN
        len_d   = len_sh_q;
`endif
        state_d = IDLE;
      end
      RUN: begin
        if (xfer_s && (cfg_data == DATA_W'(CMD_STOP))) begin
          state_d = IDLE;
        end else if (xfer_s) begin
          err_d = 1'b1;
        end else begin
          state_d = RUN;
        end
`ifdef LIF_SEQ_RUN_LIMIT_EN
        // Leave on the edge after the run_len-th timestep pulse; zero means unbounded.
        if (neuron_en_s) begin
          pulse_d = pulse_q + DATA_W'(1);
          if ((len_q != '0) && (({1'b0, pulse_q} + (DATA_W+1)'(1)) == {1'b0, len_q})) begin
            state_d = IDLE;
          end else begin
            pulse_d = pulse_q + DATA_W'(1);
          end
        end else begin
          pulse_d = pulse_q;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      thr_sh_q <= '0;
      dec_sh_q <= '0;
      ref_sh_q <= '0;
      pre_sh_q <= '0;
      thr_q    <= DATA_W'(THR_RST);
      dec_q    <= DATA_W'(DEC_RST);
      ref_q    <= DATA_W'(REF_RST);
      pre_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      upd_q    <= 1'b0;
      run_q    <= 1'b0;
`ifdef LIF_SEQ_RUN_LIMIT_EN
      len_sh_q <= '0;
      len_q    <= '0;
      pulse_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      thr_sh_q <= thr_sh_d;
      dec_sh_q <= dec_sh_d;
      ref_sh_q <= ref_sh_d;
      pre_sh_q <= pre_sh_d;
      thr_q    <= thr_d;
      dec_q    <= dec_d;
      ref_q    <= ref_d;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      ready_q  <= (state_d != APPLY);
      upd_q    <= (state_d == APPLY);
      run_q    <= (state_d == RUN);
`ifdef LIF_SEQ_RUN_LIMIT_EN
      len_sh_q <= len_sh_d;
      len_q    <= len_d;
      pulse_q  <= pulse_d;
`endif
    end
  end

  // Timestep enable follows the next state so a stop silences neuron_en immediately.
  lif_timestep_gen #(.DATA_W(DATA_W)) u_ts (
    .clk      (clk),
    .reset    (reset),
    .enable   (state_d == RUN),
    .clear    (ts_clear_s),
    .prescale (pre_q),
    .neuron_en(neuron_en_s)
  );

  assign cfg_ready         = ready_q;
  assign threshold         = thr_q;
  assign decay             = dec_q;
  assign refractory_period = ref_q;
  assign neuron_en         = neuron_en_s;
  assign cfg_update        = upd_q;
  assign running           = run_q;
  assign spike_count       = cnt_q;
  assign cmd_err           = err_q;

endmodule
